// File: rtl/reg_file_param.sv
// reg_file_param: parametrised ID-stage register file.
//   NUM_RD combinational read ports, one posedge write port, optional
//   hardwired-zero entry 0, optional write-to-read bypass, per-entry pending
//   (scoreboard) bits, and a sweep FSM that zeroes the array after reset or
//   on clear_req.
// Ports:
//   clock, reset_n      clock, synchronous active-low reset
//   rd_addr / rd_data   packed read ports, port k at [k*W +: W]
//   rd_pending          pending bit per read port
//   wr_en/addr/data     write port
//   mark_en/mark_addr   set pending bit of an issued destination
//   clear_req           one-cycle request to re-sweep the array
//   ready               array valid; low while sweeping

// Per-read-port priority mux: zero entry, then bypass, then array.
module reg_file_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] ent_data,
    input  logic              ent_pend,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data,
    output logic              pend
);
    always_comb begin
        data = '0;
        pend = 1'b0;
        if (run) begin
            if (ZERO_REG != 0 && addr == '0) begin
                data = '0;
                pend = 1'b0;
            end else if (BYPASS != 0 && wr_en && wr_addr == addr) begin
                // The completing write is the value; nothing left pending.
                data = wr_data;
                pend = 1'b0;
            end else begin
                data = ent_data;
                pend = ent_pend;
            end
        end
    end
endmodule

module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     mark_en,
    input  logic [ADDR_W-1:0]        mark_addr,
    input  logic                     clear_req,
    output logic                     ready
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic                run;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_d;
            clr_cnt <= clr_cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state;
        clr_cnt_d = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt + 1'b1;
                if (clr_cnt == ADDR_W'(DEPTH-1)) state_d = ST_RUN;
            end
            default: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    // Outputs / array write control. ready tracks RUN exactly, so it is
    // taken straight from the state flop.
    always_comb begin
        run    = (state == ST_RUN);
        ready  = run;
        mem_we = 1'b0;
        mem_wa = clr_cnt;
        mem_wd = '0;
        if (reset_n) begin
            if (!run) begin
                mem_we = 1'b1;
            end else if (wr_en && !clear_req &&
                         !(ZERO_REG != 0 && wr_addr == '0)) begin
                mem_we = 1'b1;
                mem_wa = wr_addr;
                mem_wd = wr_data;
            end
        end
    end

    // Array has no reset; the sweep is what initialises it.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Scoreboard: clear on write first, then mark, so a same-cycle mark wins.
    always_comb begin
        pend_d = pend_q;
        if (run && !clear_req) begin
            if (wr_en)   pend_d[wr_addr]   = 1'b0;
            if (mark_en) pend_d[mark_addr] = 1'b1;
        end else begin
            pend_d = '0;
        end
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a_k;
        assign a_k = rd_addr[k*ADDR_W +: ADDR_W];
        reg_file_rd_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_port (
            .run      (run),
            .addr     (a_k),
            .ent_data (mem[a_k]),
            .ent_pend (pend_q[a_k]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[k*DATA_W +: DATA_W]),
            .pend     (rd_pending[k])
        );
    end
endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic [9:0]  rd_addr;
    logic        wr_en, mark_en, clear_req;
    logic [4:0]  wr_addr, mark_addr;
    logic [31:0] wr_data;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_pend_a, rd_pend_b;
    logic        ready_a, ready_b;

    // a: BYPASS=1, b: BYPASS=0, same stimulus
    reg_file_param #(.BYPASS(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_pending(rd_pend_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .clear_req(clear_req), .ready(ready_a));
    reg_file_param #(.BYPASS(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(rd_pend_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .clear_req(clear_req), .ready(ready_b));

    typedef logic [133:0] snap_t;
    snap_t snap;
    assign snap = {ready_a, ready_b, rd_pend_a, rd_pend_b, rd_data_a, rd_data_b};
    snap_t exp_q[$];
    snap_t e;
    int checks = 0;
    int failures = 0;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    // Expected snapshot: ready, pending a/b (port1,port0), data a1,a0,b1,b0
    function automatic snap_t mk(input logic r, input logic [1:0] pa, input logic [1:0] pb,
                                 input logic [31:0] a1, input logic [31:0] a0,
                                 input logic [31:0] b1, input logic [31:0] b0);
        return {r, r, pa, pb, a1, a0, b1, b0};
    endfunction

    task automatic step(); @(posedge clock); #1; endtask
    task automatic idle(); wr_en = 0; mark_en = 0; clear_req = 0; endtask
    task automatic rd(input logic [4:0] p1, input logic [4:0] p0); rd_addr = {p1, p0}; endtask

    task automatic test_reset();
        idle(); rd(0, 0); wr_addr = 0; wr_data = 0; mark_addr = 0;
        reset_n = 0; step(); step();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL reset_state obs=%h exp=%h", snap, e); end
        reset_n = 1;
        for (int n = 1; n <= 32; n++) begin
            step();
            exp_q.push_back(mk(n == 32, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
            if (snap !== e) begin failures++; $display("FAIL sweep_ready n=%0d obs=%h exp=%h", n, snap, e); end
        end
        for (int i = 0; i < 32; i++) begin
            step(); rd(5'(31 - i), 5'(i));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
            if (snap !== e) begin failures++; $display("FAIL swept_zero i=%0d obs=%h exp=%h", i, snap, e); end
        end
    endtask

    task automatic test_write();
        step(); wr_en = 1; wr_addr = 5; wr_data = DB; rd(5, 5);
        exp_q.push_back(mk(1, 0, 0, DB, DB, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r5_same obs=%h exp=%h", snap, e); end
        step(); idle();
        exp_q.push_back(mk(1, 0, 0, DB, DB, DB, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r5 obs=%h exp=%h", snap, e); end
        step(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rd(0, 5);
        exp_q.push_back(mk(1, 0, 0, 0, DB, 0, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r0_same obs=%h exp=%h", snap, e); end
        step(); idle(); rd(0, 0);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r0 obs=%h exp=%h", snap, e); end
    endtask

    task automatic test_bypass();
        step(); wr_en = 1; wr_addr = 7; wr_data = 32'h11111111;
        step(); wr_data = A5; rd(7, 5);
        exp_q.push_back(mk(1, 0, 0, A5, DB, 32'h11111111, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL bypass_same obs=%h exp=%h", snap, e); end
        step(); idle();
        exp_q.push_back(mk(1, 0, 0, A5, DB, A5, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL bypass_next obs=%h exp=%h", snap, e); end
    endtask

    task automatic test_scoreboard();
        step(); mark_en = 1; mark_addr = 9; rd(9, 9);
        step(); idle();
        exp_q.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL mark_r9 obs=%h exp=%h", snap, e); end
        step(); wr_en = 1; wr_addr = 9; wr_data = 32'h99; rd(9, 5);
        exp_q.push_back(mk(1, 2'b00, 2'b10, 32'h99, DB, 0, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r9_bypass_pend obs=%h exp=%h", snap, e); end
        step(); idle();
        exp_q.push_back(mk(1, 2'b00, 2'b00, 32'h99, DB, 32'h99, DB)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL write_r9_clears obs=%h exp=%h", snap, e); end
        step(); wr_en = 1; wr_addr = 9; wr_data = 32'hAA; mark_en = 1; mark_addr = 9; rd(9, 9);
        exp_q.push_back(mk(1, 2'b00, 2'b00, 32'hAA, 32'hAA, 32'h99, 32'h99)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL mark_write_same obs=%h exp=%h", snap, e); end
        step(); idle();
        exp_q.push_back(mk(1, 2'b11, 2'b11, 32'hAA, 32'hAA, 32'hAA, 32'hAA)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL set_wins obs=%h exp=%h", snap, e); end
        step(); mark_en = 1; mark_addr = 0; rd(0, 9);
        step(); idle();
        exp_q.push_back(mk(1, 2'b01, 2'b01, 0, 32'hAA, 0, 32'hAA)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL mark_r0_ignored obs=%h exp=%h", snap, e); end
    endtask

    task automatic test_clear();
        step(); wr_en = 1; wr_addr = 3; wr_data = 32'h55;
        step(); clear_req = 1; wr_addr = 4; wr_data = 32'h77; mark_en = 1; mark_addr = 20;
        step(); idle(); rd(4, 3);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL clear_ready_drop obs=%h exp=%h", snap, e); end
        for (int n = 1; n <= 32; n++) begin
            step();
            if (n >= 31) begin
                exp_q.push_back(mk(n == 32, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
                if (snap !== e) begin failures++; $display("FAIL clear_sweep n=%0d obs=%h exp=%h", n, snap, e); end
            end
        end
        step(); rd(20, 9);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL clear_pending obs=%h exp=%h", snap, e); end
    endtask

    task automatic test_reset_mid_sweep();
        step(); wr_en = 1; wr_addr = 6; wr_data = 32'h66;
        step(); idle(); clear_req = 1;
        step(); idle();
        for (int i = 0; i < 10; i++) step();   // clr_cnt now 10
        reset_n = 0;
        step(); reset_n = 1; rd(6, 6);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL mid_reset_ready obs=%h exp=%h", snap, e); end
        for (int n = 1; n <= 32; n++) begin
            // Writes/marks to r6 after the sweep has passed it must be dropped
            if (n >= 8 && n < 30) begin
                wr_en = n[0]; wr_addr = 6; wr_data = 32'hFF;
                mark_en = ~n[0]; mark_addr = 6;
            end else begin
                idle();
            end
            step();
            if (n >= 31) begin
                idle();
                exp_q.push_back(mk(n == 32, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
                if (snap !== e) begin failures++; $display("FAIL mid_reset_sweep n=%0d obs=%h exp=%h", n, snap, e); end
            end
        end
        step(); rd(6, 5);
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); #1; e = exp_q.pop_front(); checks++;
        if (snap !== e) begin failures++; $display("FAIL mid_reset_r6 obs=%h exp=%h", snap, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_clear();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the pipeline register file, used in the ID stage of the 5-stage core.
- Provides NUM_RD combinational read ports and one posedge write port.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Per-entry pending (scoreboard) bits for hazard detection.
- Self-clearing sweep FSM that zeroes the array after reset or on request, replacing the simulation-only initial block.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr
rd_pending  out  NUM_RD  pending bit of each read address
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
mark_en  in  1  set pending bit at mark_addr (instruction issued with this destination)
mark_addr  in  ADDR_W  destination to mark
clear_req  in  1  request full array clear (single-cycle pulse)
ready  out  1  1 = array valid, reads/writes/marks honoured

Behaviour:
- FSM states: CLEAR, RUN.
- Reset (reset_n=0 at a rising edge):
  - state<=CLEAR, clr_cnt<=0, ready<=0, all pending<=0.
  - Array contents are untouched by reset itself; the sweep clears them.
- CLEAR state:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt<=clr_cnt+1.
  - On the cycle clr_cnt==DEPTH-1: write entry DEPTH-1, state<=RUN, ready<=1.
  - ready is first high DEPTH cycles after the first rising edge with reset_n=1 (32 with defaults).
  - wr_en, mark_en and clear_req are ignored.
  - rd_data = 0 on every port; rd_pending = 0.
- RUN state:
  - clear_req=1: state<=CLEAR, clr_cnt<=0, ready<=0, all pending<=0. A simultaneous wr_en/mark_en is dropped.
  - Write: on wr_en, entry[wr_addr]<=wr_data at the rising edge (1-cycle write latency), except entry 0 when ZERO_REG=1.
- Reads (RUN, combinational, per port k; priority order):
  1. ZERO_REG and addr==0 -> 0.
  2. BYPASS and wr_en and wr_addr==addr -> wr_data.
  3. Otherwise -> entry[addr].
  - With BYPASS=0, a same-cycle write is visible on the next cycle.
- Pending scoreboard (RUN):
  - wr_en clears pending[wr_addr].
  - mark_en sets pending[mark_addr].
  - Same address in the same cycle: set wins (a new producer supersedes the completing write).
  - ZERO_REG=1: pending[0] stays 0.
- rd_pending[k]:
  - pending[rd_addr_k] as registered.
  - Forced to 0 when the read is being satisfied by the bypass path (BYPASS=1, wr_en, wr_addr==rd_addr_k).
- Multiple read ports may use the same address; the outputs are identical.
- Reset asserted mid-sweep restarts the sweep from entry 0.
- No X on any output after the first reset edge.

Test Plan:
1. Reset 2 cycles then release -> ready=0 for 32 cycles, then 1; all 32 entries read 0x00000000 on both ports; rd_pending=2'b00.
2. RUN: write 0xDEADBEEF to r5, next cycle read r5 on port 0 and port 1 -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
3. BYPASS=1: wr_en, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr port1=7 in the same cycle -> rd_data port1=0xA5A5A5A5 combinationally. Rerun with BYPASS=0 -> old value this cycle, new value next cycle.
4. Scoreboard: mark r9 -> next cycle rd_pending=1 for a port reading r9. Write r9 -> pending cleared next cycle, and 0 in the write cycle via bypass. Mark r9 and write r9 in the same cycle -> pending stays 1.
5. Write r3=0x55 in RUN, pulse clear_req together with wr_en to r4 -> ready drops next cycle, 32-cycle sweep, then r3=0, r4=0, all pending=0.
6. Assert reset_n=0 when clr_cnt=10 during a sweep -> sweep restarts at 0; ready rises exactly 32 cycles after release; wr_en/mark_en pulses during the sweep have no effect.
